mips_multicycle_control: RTL

MIPS_MULTICYCLE_CONTROL -- requirements
Module: mips_multicycle_control

---
 rtl/mips_multicycle_control.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_control.sv
// ---------------------------------------------------------------------------
// mips_multicycle_control
//   Moore control FSM for a multicycle MIPS datapath (lw, sw, R-type, beq,
//   addi, j). It drives the datapath strobes and selects from the current
//   state and decodes the ALU operation from aluop/funct. A sticky "illegal"
//   flag records any unsupported opcode or R-type funct seen since reset.
//
// Parameters
//   ALUCTRL_W : width of alucontrol (>= 3); 3-bit codes are zero-extended
//   MEM_WAIT  : 1 = stall on mem_ready, 0 = memory is always ready
//
// Ports
//   clk, reset_n            : clock, async active-low reset
//   opcode, funct           : instruction fields from the instruction register
//   mem_ready               : memory access completes this cycle
//   pcwrite .. branch       : single-bit datapath strobes / selects
//   alusrcb, pcsrc          : 2-bit datapath muxes
//   alucontrol              : ALU operation code
//   illegal                 : sticky unsupported-instruction flag
//   state                   : current FSM state (debug)
// ---------------------------------------------------------------------------
module mips_multicycle_control #(
  parameter int ALUCTRL_W = 3,
  parameter bit MEM_WAIT  = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 mem_ready,
  output logic                 pcwrite,
  output logic                 irwrite,
  output logic                 iord,
  output logic                 memwrite,
  output logic                 regwrite,
  output logic                 regdst,
  output logic                 memtoreg,
  output logic                 alusrca,
  output logic                 branch,
  output logic [1:0]           alusrcb,
  output logic [1:0]           pcsrc,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic                 illegal,
  output logic [3:0]           state
);

  // State encodings
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTE  = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_ADDIEX   = 4'd9;
  localparam logic [3:0] S_ADDIWB   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type functs
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_MUL = 6'b011100;

  // ALU codes
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b110;
  localparam logic [2:0] ALU_MUL = 3'b101;

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic       r_illegal;
  logic       w_mem_rdy;
  logic       w_op_ok;
  logic       w_fn_ok;
  logic       w_set_illegal;
  logic [1:0] w_aluop;
  logic [2:0] w_alucode;

  // With MEM_WAIT=0 memory never stalls the FSM.
  assign w_mem_rdy = MEM_WAIT ? mem_ready : 1'b1;

  // ---------------------------------------------------------------------
  // Instruction legality
  // ---------------------------------------------------------------------
  always_comb begin
    w_op_ok = 1'b0;
    case (opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: w_op_ok = 1'b1;
      default:                                        w_op_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_fn_ok = 1'b0;
    case (funct)
      FN_ADD, FN_SUB, FN_SLT, FN_MUL: w_fn_ok = 1'b1;
      default:                        w_fn_ok = 1'b0;
    endcase
  end

  // Bad opcodes are caught in DECODE; bad functs only matter once the
  // R-type is actually executing.
  assign w_set_illegal = ((r_state == S_DECODE)  && !w_op_ok) ||
                         ((r_state == S_EXECUTE) && !w_fn_ok);

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:    w_next = w_mem_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_FETCH;
        endcase
      end
      // opcode is held in the IR, so it still selects load vs store here
      S_MEMADR:   w_next = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  w_next = w_mem_rdy ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: w_next = w_mem_rdy ? S_FETCH : S_MEMWRITE;
      S_EXECUTE:  w_next = S_ALUWB;
      S_ADDIEX:   w_next = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: w_next = S_FETCH;
      default:    w_next = S_FETCH;  // unused encodings 12-15 recover
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next;
      if (w_set_illegal) r_illegal <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Moore outputs
  // ---------------------------------------------------------------------
  always_comb begin
    pcwrite  = 1'b0;
    irwrite  = 1'b0;
    iord     = 1'b0;
    memwrite = 1'b0;
    regwrite = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    alusrca  = 1'b0;
    branch   = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    w_aluop  = 2'b00;
    case (r_state)
      S_FETCH: begin
        alusrcb = 2'b01;
        irwrite = w_mem_rdy;
        pcwrite = w_mem_rdy;
      end
      S_DECODE:   alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMREAD:  iord = 1'b1;
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_MEMWRITE: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        w_aluop = 2'b10;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        w_aluop = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWB:   regwrite = 1'b1;
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
    // Reset forces FETCH, where irwrite/pcwrite would otherwise follow
    // mem_ready; keep every strobe quiet until reset is released.
    if (!reset_n) begin
      pcwrite  = 1'b0;
      irwrite  = 1'b0;
      iord     = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
      regdst   = 1'b0;
      memtoreg = 1'b0;
      alusrca  = 1'b0;
      branch   = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // ALU decoder (pure combinational, every path assigns)
  // ---------------------------------------------------------------------
  always_comb begin
    w_alucode = ALU_ADD;
    case (w_aluop)
      2'b00: w_alucode = ALU_ADD;
      2'b01: w_alucode = ALU_SUB;
      2'b10: begin
        case (funct)
          FN_ADD:  w_alucode = ALU_ADD;
          FN_SUB:  w_alucode = ALU_SUB;
          FN_SLT:  w_alucode = ALU_SLT;
          FN_MUL:  w_alucode = ALU_MUL;
          default: w_alucode = ALU_ADD;
        endcase
      end
      default: w_alucode = ALU_ADD;
    endcase
  end

  assign alucontrol = ALUCTRL_W'(w_alucode);
  assign illegal    = r_illegal;
  assign state      = r_state;

endmodule
